// File: rtl/rtu_link_timing_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rtu_link_timing_buffer                                         |
// | Brief   : Modbus-RTU 1.5T/3.5T silence timers plus true dual-port RAM    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rtu_link_timing_buffer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int A_WIDTH   = 2,
  parameter int D_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_done,
  input  logic               rx_state,
  output logic               rx_drop_frame,
  output logic               rx_new_frame,
  input  logic               ena,
  input  logic               wea,
  input  logic [A_WIDTH-1:0] addra,
  input  logic [D_WIDTH-1:0] dia,
  output logic [D_WIDTH-1:0] doa,
  input  logic               enb,
  input  logic               web,
  input  logic [A_WIDTH-1:0] addrb,
  input  logic [D_WIDTH-1:0] dib,
  output logic [D_WIDTH-1:0] dob
);

  // 64-bit math: CLK_FREQ*77 overflows a 32-bit int at the default clock.
  localparam logic [63:0] c_CNT_15T = (64'(CLK_FREQ) * 64'd33) / (64'd2 * 64'(BAUD_RATE));
  localparam logic [63:0] c_CNT_35T = (64'(CLK_FREQ) * 64'd77) / (64'd2 * 64'(BAUD_RATE));
  localparam int          c_CW      = $clog2(c_CNT_35T + 64'd1);
  localparam int          c_DEPTH   = 1 << A_WIDTH;

  logic [1:0] w_pulse;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_timer
      localparam logic [c_CW-1:0] c_LAST = (g == 0) ? c_CW'(c_CNT_15T - 64'd1)
                                                     : c_CW'(c_CNT_35T - 64'd1);
      logic [c_CW-1:0] r_cnt;
      logic            r_armed;
      logic            r_pulse;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_armed <= 1'b0;
          r_pulse <= 1'b0;
        end else if (rx_done) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
          r_pulse <= 1'b0;
        end else if (rx_state) begin
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end else if (r_armed) begin
          // Disarming on the pulse guarantees one pulse per silence period.
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_pulse <= 1'b0;
          end
        end else begin
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end
      end

      assign w_pulse[g] = r_pulse;
    end
  endgenerate

  assign rx_drop_frame = w_pulse[0];
  assign rx_new_frame  = w_pulse[1];

  logic [D_WIDTH-1:0] r_mem [c_DEPTH];
  logic [D_WIDTH-1:0] r_doa;
  logic [D_WIDTH-1:0] r_dob;

  // Port A write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (enb && web) r_mem[addrb] <= dib;
    if (ena && wea) r_mem[addra] <= dia;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doa <= '0;
      r_dob <= '0;
    end else begin
      if (ena) r_doa <= r_mem[addra];
      if (enb) r_dob <= r_mem[addrb];
    end
  end

  assign doa = r_doa;
  assign dob = r_dob;

endmodule
`default_nettype wire

// File: tb/tb_rtu_link_timing_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rtu_link_timing_buffer                                      |
// | Brief   : Directed self-checking bench for rtu_link_timing_buffer        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rtu_link_timing_buffer;

  localparam int c_T15 = 7161;
  localparam int c_T35 = 16710;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic        rx_state;
  logic        rx_drop_frame;
  logic        rx_new_frame;
  logic        ena, wea, enb, web;
  logic [1:0]  addra, addrb;
  logic [15:0] dia, dib, doa, dob;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, drop_at, new_at, drop_cnt, new_cnt;

  rtu_link_timing_buffer #(
    .CLK_FREQ (50000000),
    .BAUD_RATE(115200),
    .A_WIDTH  (2),
    .D_WIDTH  (16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done      (rx_done),
    .rx_state     (rx_state),
    .rx_drop_frame(rx_drop_frame),
    .rx_new_frame (rx_new_frame),
    .ena          (ena),
    .wea          (wea),
    .addra        (addra),
    .dia          (dia),
    .doa          (doa),
    .enb          (enb),
    .web          (web),
    .addrb        (addrb),
    .dib          (dib),
    .dob          (dob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle index is relative to the edge that sampled the last rx_done.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_drop_frame) begin drop_cnt++; drop_at = cyc; end
    if (rx_new_frame)  begin new_cnt++;  new_at  = cyc; end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    drop_cnt = 0; new_cnt = 0; drop_at = -1; new_at = -1;
  endtask

  task automatic byte_done();
    rx_state = 1'b0;
    rx_done  = 1'b1;
    tick();
    rx_done  = 1'b0;
    cyc      = 0;
  endtask

  initial begin
    logic [2:0] a5;
    rst_n = 1'b0; rx_done = 1'b0; rx_state = 1'b0;
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    cyc = 0; clr();
    step(3);
    check("rst_drop", 32'(rx_drop_frame), 32'd0);
    check("rst_new",  32'(rx_new_frame),  32'd0);
    check("rst_doa",  32'(doa), 32'd0);
    check("rst_dob",  32'(dob), 32'd0);
    rst_n = 1'b1;

    step(100);
    check("idle_drop_cnt", 32'(drop_cnt), 32'd0);
    check("idle_new_cnt",  32'(new_cnt),  32'd0);

    // Single byte followed by silence
    clr(); byte_done(); step(c_T35 + 300);
    check("t1_drop_at",  32'(drop_at),  32'(c_T15));
    check("t1_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t1_new_at",   32'(new_at),   32'(c_T35));
    check("t1_new_cnt",  32'(new_cnt),  32'd1);

    // Burst of eight bytes with short gaps
    clr();
    for (int b = 0; b < 8; b++) begin
      rx_state = 1'b1; step(300);
      byte_done();
      if (b != 7) step(50);
    end
    check("t2_burst_drop", 32'(drop_cnt), 32'd0);
    check("t2_burst_new",  32'(new_cnt),  32'd0);
    clr(); step(c_T35 + 300);
    check("t2_drop_at",  32'(drop_at),  32'(c_T15));
    check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t2_new_at",   32'(new_at),   32'(c_T35));
    check("t2_new_cnt",  32'(new_cnt),  32'd1);

    // Byte starts before 1.5T: both pulses suppressed
    clr(); byte_done(); step(5000);
    rx_state = 1'b1; step(4340);
    byte_done();
    check("t3_gap_drop", 32'(drop_cnt), 32'd0);
    check("t3_gap_new",  32'(new_cnt),  32'd0);

    // Byte starts between 1.5T and 3.5T: only the drop pulse
    clr(); step(10000);
    check("t4_drop_at",  32'(drop_at),  32'(c_T15));
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    rx_state = 1'b1; step(2000);
    check("t4_new_cnt",  32'(new_cnt),  32'd0);
    clr(); byte_done(); step(c_T35 + 200);
    check("t4b_drop_at", 32'(drop_at),  32'(c_T15));
    check("t4b_new_at",  32'(new_at),   32'(c_T35));
    check("t4b_new_cnt", 32'(new_cnt),  32'd1);

    // RAM fill on port A, read back on port B
    ena = 1'b1; wea = 1'b1;
    addra = 2'd0; dia = 16'h0451; tick();
    addra = 2'd1; dia = 16'h5347; tick();
    addra = 2'd2; dia = 16'h7414; tick();
    addra = 2'd3; dia = 16'h2021; tick();
    ena = 1'b0; wea = 1'b0;
    enb = 1'b1; web = 1'b0;
    addrb = 2'd0; tick(); check("rd_b0", 32'(dob), 32'h0451);
    addrb = 2'd1; tick(); check("rd_b1", 32'(dob), 32'h5347);
    addrb = 2'd2; tick(); check("rd_b2", 32'(dob), 32'h7414);
    addrb = 2'd3; tick(); check("rd_b3", 32'(dob), 32'h2021);
    enb = 1'b0;

    a5 = 3'd5;
    ena = 1'b1; addra = a5[1:0]; tick();
    check("alias_a5", 32'(doa), 32'h5347);

    wea = 1'b1; addra = 2'd3; dia = 16'h9999; tick();
    check("rdfirst_a", 32'(doa), 32'h2021);

    // Same-address write collision: A wins, both read old data
    addra = 2'd2; dia = 16'hAAAA;
    enb = 1'b1; web = 1'b1; addrb = 2'd2; dib = 16'h5555; tick();
    check("coll_doa", 32'(doa), 32'h7414);
    check("coll_dob", 32'(dob), 32'h7414);
    ena = 1'b0; wea = 1'b0; web = 1'b0; tick();
    check("coll_win", 32'(dob), 32'hAAAA);

    ena = 1'b1; wea = 1'b1; addra = 2'd0; dia = 16'h1111; addrb = 2'd0; tick();
    check("xport_old", 32'(dob), 32'h0451);
    ena = 1'b0; wea = 1'b0; tick();
    check("xport_new", 32'(dob), 32'h1111);

    enb = 1'b0; web = 1'b1; addrb = 2'd3; dib = 16'hDEAD; tick();
    check("hold_dob", 32'(dob), 32'h1111);
    enb = 1'b1; web = 1'b0; tick();
    check("hold_nowr", 32'(dob), 32'h9999);
    enb = 1'b0;

    // Asynchronous reset in the middle of a count
    clr(); byte_done(); step(3000);
    rst_n = 1'b0; #1;
    check("arst_doa", 32'(doa), 32'd0);
    check("arst_dob", 32'(dob), 32'd0);
    tick();
    rst_n = 1'b1;
    clr(); step(c_T15 + 200);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("arst_new_cnt",  32'(new_cnt),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
